// File: rtl/bin2bcd_serial_if.sv
// rtl/bin2bcd_serial_if.sv - request/result bundle between a binary producer and the BCD converter
interface bin2bcd_serial_if #(
    parameter int W = 26,
    parameter int D = 8
);
    logic             start;
    logic [W-1:0]     bin;
    logic             busy;
    logic             done;
    logic [4*D-1:0]   bcd;
    logic [3:0]       ndig;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ndig
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ndig
    );
endinterface

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - one-bit-per-clock double-dabble binary to packed BCD converter
module bin2bcd_serial #(
    parameter int W = 26,
    parameter int D = 8
) (
    input  logic            clk,
    input  logic            rst,
    bin2bcd_serial_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   shreg;
    logic [4*D-1:0] scratch;
    logic [4*D-1:0] corr;
    logic [4*D-1:0] scratch_nxt;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           done_q;
    logic [4*D-1:0] bcd_q;
    logic [3:0]     ndig_q;
    logic [3:0]     ndig_nxt;

    assign last = (cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONV;
            CONV:    if (last)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CONV);
        bus.done = done_q;
        bus.bcd  = bcd_q;
        bus.ndig = ndig_q;
    end

    // Add-3 is confined to each nibble of the scratch; the shift register never sees it.
    always_comb begin
        corr = scratch;
        for (int i = 0; i < D; i++) begin
            if (corr[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = corr[4*i +: 4] + 4'd3;
            end
        end
        scratch_nxt = {corr[4*D-2:0], shreg[W-1]};
    end

    // Highest nonzero digit wins; an all-zero result still reports one digit.
    always_comb begin
        ndig_nxt = 4'd1;
        for (int i = 0; i < D; i++) begin
            if (scratch_nxt[4*i +: 4] != 4'd0) begin
                ndig_nxt = 4'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ndig_q  <= 4'd1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                CONV: begin
                    shreg   <= {shreg[W-2:0], 1'b0};
                    scratch <= scratch_nxt;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        bcd_q  <= scratch_nxt;
                        ndig_q <= ndig_nxt;
                        done_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
